// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and capture FSM state type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE - 1;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned PIX_W = 12;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } capture_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-stage sampling of hsync/vsync with registered falling-edge strobes.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic hsync,
  input  logic vsync,
  output logic h_fall,
  output logic v_fall
);

  logic [1:0] s1;
  logic [1:0] s2;

  // Syncs idle high, so reset to 1 to treat a low level at start-up as a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 2'b11;
      s2     <= 2'b11;
      h_fall <= 1'b0;
      v_fall <= 1'b0;
    end else begin
      s1     <= {hsync, vsync};
      s2     <= s1;
      h_fall <= s2[1] & ~s1[1];
      v_fall <= s2[0] & ~s1[0];
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA receive path: recovers x/y from sync timing, locks after one clean
// frame, and emits 4:4:4 pixels with timing-error strobes.
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT = vga_pkg::H_FP,
  parameter int unsigned H_PULSE = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK  = vga_pkg::H_BP,
  parameter int unsigned V_ACT   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT = vga_pkg::V_FP,
  parameter int unsigned V_PULSE = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK  = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  output logic [PIX_W-1:0] pixel,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_valid,
  output logic             frame_start,
  output logic             locked,
  output logic             h_err,
  output logic             v_err
);

  localparam logic [CNT_W-1:0] HT      = CNT_W'(H_ACT + H_FRONT + H_PULSE + H_BACK);
  localparam logic [CNT_W-1:0] VT      = CNT_W'(V_ACT + V_FRONT + V_PULSE + V_BACK);
  localparam logic [CNT_W-1:0] HT_LAST = CNT_W'(H_ACT + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [CNT_W-1:0] VT_LAST = CNT_W'(V_ACT + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_PULSE + H_BACK);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_PULSE + H_BACK + H_ACT - 1);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_PULSE + V_BACK);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_PULSE + V_BACK + V_ACT - 1);

  logic             h_fall;
  logic             v_fall;
  logic [PIX_W-1:0] rgb_s1;
  logic [PIX_W-1:0] rgb_s2;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_cnt_nxt;
  logic [CNT_W-1:0] v_cnt_nxt;
  logic             h_bad;
  logic             v_bad;
  logic             checking;
  logic             in_win;
  logic             valid_nxt;
  logic             unused_lsbs;
  capture_state_t   state;
  capture_state_t   state_nxt;

  assign unused_lsbs = ^{r[3:0], g[3:0], b[3:0]};

  vga_sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .hsync  (hsync),
    .vsync  (vsync),
    .h_fall (h_fall),
    .v_fall (v_fall)
  );

  // Next counter values belong to the sample now leaving the colour pipeline.
  always_comb begin
    h_cnt_nxt = (h_cnt == HT) ? HT : h_cnt + CNT_W'(1);
    v_cnt_nxt = v_cnt;
    if (h_fall) begin
      h_cnt_nxt = '0;
      v_cnt_nxt = v_fall ? '0 : ((v_cnt == VT) ? VT : v_cnt + CNT_W'(1));
    end

    h_bad = h_fall ? (h_cnt != HT_LAST) : (h_cnt == HT_LAST);
    v_bad = (v_fall && (!h_fall || v_cnt != VT_LAST)) ||
            (h_fall && !v_fall && v_cnt == VT_LAST);
    checking = (state != UNLOCKED);

    state_nxt = state;
    case (state)
      UNLOCKED: if (h_fall && v_fall) state_nxt = ACQUIRE;
      ACQUIRE:  if (h_bad || v_bad) state_nxt = UNLOCKED;
                else if (v_fall)    state_nxt = LOCKED;
      LOCKED:   if (h_bad || v_bad) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase

    in_win = (h_cnt_nxt >= H_LO) && (h_cnt_nxt <= H_HI) &&
             (v_cnt_nxt >= V_LO) && (v_cnt_nxt <= V_HI);
    valid_nxt = (state_nxt == LOCKED) && in_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      h_cnt       <= HT;
      v_cnt       <= VT;
      rgb_s1      <= '0;
      rgb_s2      <= '0;
      pixel       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      h_cnt       <= h_cnt_nxt;
      v_cnt       <= v_cnt_nxt;
      rgb_s1      <= {r[7:4], g[7:4], b[7:4]};
      rgb_s2      <= rgb_s1;
      locked      <= (state_nxt == LOCKED);
      h_err       <= checking & h_bad;
      v_err       <= checking & v_bad;
      pix_valid   <= valid_nxt;
      frame_start <= valid_nxt && (h_cnt_nxt == H_LO) && (v_cnt_nxt == V_LO);
      // Pixel and coordinates hold their last values outside the window.
      if (valid_nxt) begin
        pixel <= rgb_s2;
        pix_x <= X_W'(h_cnt_nxt - H_LO);
        pix_y <= Y_W'(v_cnt_nxt - V_LO);
      end
    end
  end

endmodule
